// File: rtl/lm80c_ram_arbiter_if.sv
// Bus bundle between the lm80c core, the program downloader and the system RAM port.
// master = requesters plus RAM model side, slave = the arbiter.
interface lm80c_ram_arbiter_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [7:0]  cpu_rdata;
   logic        cpu_wait;
   logic [15:0] dl_addr;
   logic [7:0]  dl_data;
   logic        dl_wr;
   logic        dl_ready;
   logic        dl_overrun;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_rd;
   logic [7:0]  mem_q;

   modport master (
      output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, dl_addr, dl_data, dl_wr, mem_q,
      input  cpu_rdata, cpu_wait, dl_ready, dl_overrun, mem_addr, mem_wdata, mem_we, mem_rd
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, dl_addr, dl_data, dl_wr, mem_q,
      output cpu_rdata, cpu_wait, dl_ready, dl_overrun, mem_addr, mem_wdata, mem_we, mem_rd
   );
endinterface

// File: rtl/lm80c_ram_arbiter.sv
// Shares the 64K x 8 system RAM between the Z80 bus and the program downloader,
// stretching CPU cycles through WAIT and buffering one downloader write.
//
// state  | meaning
// IDLE   | arbitrate between the downloader holding register and the CPU request
// DL_WR  | mem_we pulse with the held downloader address/data
// CPU_WR | mem_we pulse with the CPU address/data, CPU access completes
// CPU_RD | mem_rd issued on entry, count down the RAM latency, then capture mem_q
module lm80c_ram_arbiter #(
   parameter int RD_LAT       = 2,
   parameter int MAX_DL_BURST = 4
) (
   input logic                 sys_clock,
   input logic                 RESET_n,
   lm80c_ram_arbiter_if.slave  bus
);

   localparam int BURST_W = $clog2(MAX_DL_BURST + 1);

   typedef enum logic [1:0] {IDLE, DL_WR, CPU_WR, CPU_RD} state_t;

   state_t               state, state_d;
   logic                 cpu_done;
   logic                 cpu_pending;
   logic                 dl_full;
   logic [15:0]          dl_addr_q;
   logic [7:0]           dl_data_q;
   logic [BURST_W-1:0]   burst;
   logic [2:0]           lat_cnt;
   logic [7:0]           cpu_rdata_q;
   logic [15:0]          mem_addr_q;
   logic [7:0]           mem_wdata_q;
   logic                 mem_we_q;
   logic                 mem_rd_q;
   logic                 dl_overrun_q;

   logic                 dl_grant;
   logic                 cpu_wr_go;
   logic                 cpu_rd_go;
   logic                 rd_capture;

   assign cpu_pending    = (bus.cpu_rd | bus.cpu_wr) & ~cpu_done;
   assign bus.cpu_wait   = cpu_pending;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.dl_ready   = ~dl_full;
   assign bus.dl_overrun = dl_overrun_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_rd     = mem_rd_q;

   always_comb begin
      state_d    = state;
      dl_grant   = 1'b0;
      cpu_wr_go  = 1'b0;
      cpu_rd_go  = 1'b0;
      rd_capture = 1'b0;
      unique case (state)
         IDLE: begin
            if (dl_full && (!cpu_pending || burst < BURST_W'(MAX_DL_BURST))) begin
               state_d  = DL_WR;
               dl_grant = 1'b1;
            end else if (cpu_pending && bus.cpu_wr) begin
               state_d   = CPU_WR;
               cpu_wr_go = 1'b1;
            end else if (cpu_pending) begin
               state_d   = CPU_RD;
               cpu_rd_go = 1'b1;
            end
         end
         DL_WR:  state_d = IDLE;
         CPU_WR: state_d = IDLE;
         CPU_RD: begin
            if (lat_cnt == 3'd0) begin
               state_d    = IDLE;
               rd_capture = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clock or negedge RESET_n) begin
      if (!RESET_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Memory strobes and address/data are registered on the edge that enters the access state.
   always_ff @(posedge sys_clock or negedge RESET_n) begin
      if (!RESET_n) begin
         mem_we_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 8'h00;
         lat_cnt     <= 3'd0;
         cpu_rdata_q <= 8'h00;
         cpu_done    <= 1'b0;
         burst       <= '0;
      end else begin
         mem_we_q <= dl_grant | cpu_wr_go;
         mem_rd_q <= cpu_rd_go;
         if (dl_grant) begin
            mem_addr_q  <= dl_addr_q;
            mem_wdata_q <= dl_data_q;
         end else if (cpu_wr_go) begin
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
         end else if (cpu_rd_go) begin
            mem_addr_q  <= bus.cpu_addr;
         end

         if (cpu_rd_go) begin
            lat_cnt <= 3'(RD_LAT);
         end else if (state == CPU_RD && lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
         end

         if (rd_capture) begin
            cpu_rdata_q <= bus.mem_q;
         end

         if (!(bus.cpu_rd | bus.cpu_wr)) begin
            cpu_done <= 1'b0;
         end else if (state == CPU_WR || rd_capture) begin
            cpu_done <= 1'b1;
         end

         if (dl_grant) begin
            burst <= cpu_pending ? burst + 1'b1 : '0;
         end else if (cpu_wr_go || cpu_rd_go) begin
            burst <= '0;
         end
      end
   end

   // A strobe landing in the grant cycle refills the register the write is draining.
   always_ff @(posedge sys_clock or negedge RESET_n) begin
      if (!RESET_n) begin
         dl_full      <= 1'b0;
         dl_addr_q    <= 16'h0000;
         dl_data_q    <= 8'h00;
         dl_overrun_q <= 1'b0;
      end else begin
         if (bus.dl_wr) begin
            if (!dl_full || dl_grant) begin
               dl_full   <= 1'b1;
               dl_addr_q <= bus.dl_addr;
               dl_data_q <= bus.dl_data;
            end else begin
               dl_overrun_q <= 1'b1;
            end
         end else if (dl_grant) begin
            dl_full <= 1'b0;
         end
      end
   end

endmodule
